// File: rtl/menu_buf_pkg.sv
// Shared types and defaults for the menu/text character buffer and the
// writers that target it (arbiter, config-menu writer, status-line writer).
package menu_buf_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCKED = 2'd1,
        CLEAR  = 2'd2
    } arb_state_t;

    localparam int MENU_COLS     = 80;
    localparam int MENU_ROWS     = 10;
    localparam int NUM_REQ_DEF   = 3;
    localparam int ADDR_W_DEF    = 10;
    localparam int DATA_W_DEF    = 8;
    localparam int BUF_DEPTH_DEF = MENU_COLS * MENU_ROWS;
    localparam int CNT_W         = 16;
    localparam logic [7:0] FILL_CHAR_DEF = 8'h20;

    // Linear buffer address of a row/column position on the menu screen.
    function automatic logic [ADDR_W_DEF-1:0] menu_addr(input int unsigned row,
                                                        input int unsigned col);
        return ADDR_W_DEF'(row * MENU_COLS + col);
    endfunction

endpackage

// File: rtl/menu_buf_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first set bit of
// valid_i at or after ptr_i (wrapping at NUM_REQ) as a one-hot grant and index.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Scan offsets from farthest to nearest so the nearest valid writer wins.
    always_comb begin
        int cand;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (valid_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                idx_o         = IDX_W'(cand);
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/menu_buf_arbiter.sv
// menu_buf_arbiter: round-robin write arbiter with burst lock and a built-in
// clear sequencer in front of the menu/text buffer BRAM write port.
// Optional feature macro: MENU_ARB_STATS_EN adds per-writer 16-bit saturating
// counters of in-range writes on grant_cnt_out.
module menu_buf_arbiter
    import menu_buf_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(FILL_CHAR_DEF)
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [NUM_REQ-1:0]        req_valid_in,
    input  logic [NUM_REQ-1:0]        req_lock_in,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
    output logic [NUM_REQ-1:0]        req_ready_out,
    input  logic                      clear_start_in,
    output logic                      clear_busy_out,
    output logic                      buf_we_out,
    output logic [ADDR_W-1:0]         buf_addr_out,
    output logic [DATA_W-1:0]         buf_data_out,
    output logic                      addr_err_out
`ifdef MENU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt_out
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(BUF_DEPTH);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               clear_pending_q, clear_pending_d;
    logic               clear_tail_q, clear_tail_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;

    logic               buf_we_q, buf_we_d;
    logic [ADDR_W-1:0]  buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]  buf_data_q, buf_data_d;
    logic               addr_err_q, addr_err_d;

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] elig_mask;
    logic [NUM_REQ-1:0] pick_valid;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   win_next;
    logic               xfer;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;
    logic               win_lock;
    logic               in_range;
    logic               start_acc;
    logic               clr_last;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr_in[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid_i (pick_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (xfer)
    );

    assign win_addr  = addr_arr[win_idx];
    assign win_data  = data_arr[win_idx];
    assign win_lock  = req_lock_in[win_idx];
    assign in_range  = ({1'b0, win_addr} < DEPTH_EXT);
    assign win_next  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign clr_last  = (clr_addr_q == LAST_ADDR);
    // A start pulse during an active or finishing clear is ignored.
    assign start_acc = clear_start_in & ~clear_busy_out;

    assign req_ready_out  = grant;
    assign clear_busy_out = clear_pending_q | clear_tail_q;
    assign buf_we_out     = buf_we_q;
    assign buf_addr_out   = buf_addr_q;
    assign buf_data_out   = buf_data_q;
    assign addr_err_out   = addr_err_q;

    // State register: FSM state, round-robin pointer, lock owner, clear tracking.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q         <= ARB;
            rr_ptr_q        <= '0;
            owner_q         <= '0;
            clear_pending_q <= 1'b0;
            clear_tail_q    <= 1'b0;
            clr_addr_q      <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            owner_q         <= owner_d;
            clear_pending_q <= clear_pending_d;
            clear_tail_q    <= clear_tail_d;
            clr_addr_q      <= clr_addr_d;
        end
    end

    // Next-state logic: grant/lock transitions and the clear walk.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        owner_d         = owner_q;
        clr_addr_d      = '0;
        clear_pending_d = clear_pending_q | start_acc;
        clear_tail_d    = 1'b0;
        case (state_q)
            ARB, LOCKED: begin
                if (xfer) begin
                    rr_ptr_d = win_next;
                    if (win_lock) begin
                        state_d = LOCKED;
                        owner_d = win_idx;
                    end else if (clear_pending_q || start_acc) begin
                        state_d = CLEAR;
                    end else begin
                        state_d = ARB;
                    end
                end else if (state_q == ARB && (clear_pending_q || start_acc)) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    state_d         = ARB;
                    clear_pending_d = 1'b0;
                    clear_tail_d    = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Output logic: who may be granted now, and what the BRAM port sees next.
    always_comb begin
        elig_mask = '0;
        case (state_q)
            ARB:     elig_mask = clear_pending_q ? '0 : '1;
            LOCKED: begin
                elig_mask          = '0;
                elig_mask[owner_q] = 1'b1;
            end
            default: elig_mask = '0;
        endcase
        pick_valid = req_valid_in & elig_mask;

        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        addr_err_d = 1'b0;
        if (state_q == CLEAR) begin
            buf_we_d   = 1'b1;
            buf_addr_d = clr_addr_q;
            buf_data_d = FILL_CHAR;
        end else if (xfer) begin
            if (in_range) begin
                buf_we_d   = 1'b1;
                buf_addr_d = win_addr;
                buf_data_d = win_data;
            end else begin
                addr_err_d = 1'b1;
            end
        end
    end

    // BRAM write-port registers (one cycle after the accepted beat).
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            buf_we_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            addr_err_q <= addr_err_d;
        end
    end

`ifdef MENU_ARB_STATS_EN
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [CNT_W-1:0] cnt_q;
            // Saturating count of this writer's in-range writes.
            always_ff @(posedge clk_in) begin
                if (!rst_n_in) begin
                    cnt_q <= '0;
                end else if (grant[gi] && in_range && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            assign grant_cnt_out[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate
`endif

endmodule
